// File: rtl/ch_buffer_reader.sv
// ch_buffer_reader: circular word buffer with a 4-phase req/ack reader port
module ch_buffer_reader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic             rd_req,
    output logic             rd_ack,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      level,
    output logic [7:0]       drop_cnt
);
    localparam logic [0:0]  IDLE       = 1'b0;
    localparam logic [0:0]  ACK        = 1'b1;
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [0:0]       state;
    logic             full, empty, push, pop;
    assign full     = level == FULL_LEVEL;
    assign empty    = level == '0;
    assign wr_ready = !full;
    assign push     = wr_valid && !full;
    assign pop      = state == IDLE && rd_req && !empty;
    assign rd_ack   = state == ACK;
    // storage write; contents need no reset because level gates every read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end
    // write pointer, occupancy and saturating drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            level    <= '0;
            drop_cnt <= '0;
        end else begin
            wr_ptr   <= push ? wr_ptr + 1'b1 : wr_ptr;
            level    <= level + (AW+1)'(push) - (AW+1)'(pop);
            drop_cnt <= (wr_valid && full && drop_cnt != 8'hFF) ? drop_cnt + 8'd1 : drop_cnt;
        end
    end
    // reader handshake: pop on entry to ACK, hold until the request drops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            state   <= pop ? ACK : (state == ACK && !rd_req) ? IDLE : state;
            rd_ptr  <= pop ? rd_ptr + 1'b1 : rd_ptr;
            rd_data <= pop ? mem[rd_ptr] : rd_data;
        end
    end
endmodule

// File: tb/tb_ch_buffer_reader.sv
// tb_ch_buffer_reader: vector table plus scoreboard bench for ch_buffer_reader
module tb_ch_buffer_reader;
    logic       clk = 0, rst = 1;
    logic [7:0] wr_data = 0;
    logic       wr_valid = 0, rd_req = 0;
    logic       wr_ready, rd_ack;
    logic [7:0] rd_data, drop_cnt;
    logic [2:0] level;

    ch_buffer_reader #(.WIDTH(8), .DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .rd_req(rd_req), .rd_ack(rd_ack),
        .rd_data(rd_data), .level(level), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic       rq;
        int         lvl;
        logic       rdy;
        logic       ack;
        int         drop;
        logic [7:0] data;
    } vec_t;

    vec_t       tbl[16];
    logic [7:0] sb[$];
    int         checks = 0, errors = 0;
    int         m_level = 0, m_drop = 0, m_state = 0;
    logic       popped;
    logic [7:0] exp_data;
    int         last;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_level = 0;
        m_drop  = 0;
        m_state = 0;
    endtask

    // one clock: drive inputs, advance the reference model, compare after the edge
    task automatic step(input logic wv, input logic [7:0] wd, input logic rq);
        logic m_push, m_full;
        wr_valid = wv;
        wr_data  = wd;
        rd_req   = rq;
        m_full = m_level == 4;
        m_push = wv && !m_full;
        popped = m_state == 0 && rq && m_level != 0;
        if (wv && m_full && m_drop < 255) m_drop++;
        if (popped) exp_data = sb.pop_front();
        if (m_push) sb.push_back(wd);
        m_level = m_level + int'(m_push) - int'(popped);
        if (popped) m_state = 1;
        else if (m_state == 1 && !rq) m_state = 0;
        @(posedge clk);
        #1;
        chk("level", int'(level), m_level);
        chk("wr_ready", int'(wr_ready), int'(m_level != 4));
        chk("rd_ack", int'(rd_ack), m_state);
        chk("drop_cnt", int'(drop_cnt), m_drop);
        if (popped) chk("rd_data", int'(rd_data), int'(exp_data));
    endtask

    initial begin
        tbl[0]  = '{1'b1, 8'h11, 1'b0, 1, 1'b1, 1'b0, 0, 8'h00};
        tbl[1]  = '{1'b1, 8'h22, 1'b0, 2, 1'b1, 1'b0, 0, 8'h00};
        tbl[2]  = '{1'b1, 8'h33, 1'b0, 3, 1'b1, 1'b0, 0, 8'h00};
        tbl[3]  = '{1'b1, 8'h44, 1'b0, 4, 1'b0, 1'b0, 0, 8'h00};
        tbl[4]  = '{1'b1, 8'h55, 1'b0, 4, 1'b0, 1'b0, 1, 8'h00};
        tbl[5]  = '{1'b1, 8'h66, 1'b0, 4, 1'b0, 1'b0, 2, 8'h00};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 3, 1'b1, 1'b1, 2, 8'h11};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 3, 1'b1, 1'b1, 2, 8'h11};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 3, 1'b1, 1'b0, 2, 8'h11};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 2, 1'b1, 1'b1, 2, 8'h22};
        tbl[10] = '{1'b1, 8'h77, 1'b0, 3, 1'b1, 1'b0, 2, 8'h22};
        tbl[11] = '{1'b1, 8'h88, 1'b1, 3, 1'b1, 1'b1, 2, 8'h33};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 3, 1'b1, 1'b0, 2, 8'h33};
        tbl[13] = '{1'b1, 8'h99, 1'b0, 4, 1'b0, 1'b0, 2, 8'h33};
        tbl[14] = '{1'b1, 8'hAA, 1'b1, 3, 1'b1, 1'b1, 3, 8'h44};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 3, 1'b1, 1'b0, 3, 8'h44};

        #12;
        chk("rst_level", int'(level), 0);
        chk("rst_wr_ready", int'(wr_ready), 1);
        chk("rst_rd_ack", int'(rd_ack), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_drop_cnt", int'(drop_cnt), 0);
        rst = 0;
        @(posedge clk);
        #1;

        // fill, overflow, and interleaved push/pop including pop while full
        foreach (tbl[i]) begin
            step(tbl[i].wv, tbl[i].wd, tbl[i].rq);
            chk($sformatf("tbl%0d_level", i), int'(level), tbl[i].lvl);
            chk($sformatf("tbl%0d_ready", i), int'(wr_ready), int'(tbl[i].rdy));
            chk($sformatf("tbl%0d_ack", i), int'(rd_ack), int'(tbl[i].ack));
            chk($sformatf("tbl%0d_drop", i), int'(drop_cnt), tbl[i].drop);
            chk($sformatf("tbl%0d_data", i), int'(rd_data), int'(tbl[i].data));
        end

        // drain 0x77, 0x88, 0x99
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1);
            step(1'b0, 8'h00, 1'b0);
        end
        chk("drained_level", int'(level), 0);

        // request on empty buffer waits for the first push
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("empty_wait_ack", int'(rd_ack), 0);
        step(1'b1, 8'hA5, 1'b1);
        chk("a5_no_writethrough", int'(rd_ack), 0);
        step(1'b0, 8'h00, 1'b1);
        chk("a5_ack", int'(rd_ack), 1);
        chk("a5_data", int'(rd_data), 8'hA5);
        step(1'b0, 8'h00, 1'b0);
        chk("a5_ack_drop", int'(rd_ack), 0);
        chk("a5_level", int'(level), 0);

        // continuous writer against a 4-phase reader; values must only increase
        last = -1;
        for (int d = 0; d <= 20; d++) begin
            step(1'b1, 8'(d), m_state == 0);
            if (popped) begin
                chk("t4_increasing", int'(int'(rd_data) > last), 1);
                last = int'(rd_data);
            end
        end
        for (int i = 0; i < 40 && (m_level != 0 || m_state != 0); i++) begin
            step(1'b0, 8'h00, m_state == 0);
            if (popped) begin
                chk("t4_increasing", int'(int'(rd_data) > last), 1);
                last = int'(rd_data);
            end
        end
        chk("t4_drained", int'(level), 0);
        chk("t4_last_word", last, 20);

        // asynchronous reset in the middle of an ACK with two words stored
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        step(1'b1, 8'h03, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("pre_rst_level", int'(level), 2);
        #2 rst = 1;
        #1;
        chk("async_rst_ack", int'(rd_ack), 0);
        chk("async_rst_level", int'(level), 0);
        chk("async_rst_drop", int'(drop_cnt), 0);
        chk("async_rst_data", int'(rd_data), 0);
        rd_req = 0;
        model_reset();
        @(posedge clk);
        #1 rst = 0;
        step(1'b1, 8'h5C, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("post_rst_data", int'(rd_data), 8'h5C);
        step(1'b0, 8'h00, 1'b0);

        // drop counter saturates at 255
        for (int i = 0; i < 4; i++) step(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, 8'hEE, 1'b0);
        chk("drop_saturated", int'(drop_cnt), 255);
        chk("full_level", int'(level), 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
